// File: rtl/puf_response_collector.sv
// ---------------------------------------------------------------------------
// puf_response_collector
//
// Sits behind the arbiter flip-flop at the end of an arbiter-PUF's two delay
// chains. For every response bit it launches VOTES races. Each race waits
// SETTLE_CYCLES cycles and then samples the arbiter output. The bit is the
// majority of those samples. When all RESP_BITS bits are collected, the
// response is offered to the consumer with a valid/ready handshake.
//
// Timing of one bit:
//   VOTES x (FIRE + SETTLE_CYCLES x SETTLE + SAMPLE), then one DECIDE cycle.
// resp_valid goes high RESP_BITS*(VOTES*(SETTLE_CYCLES+2)+1) cycles after
// the edge that accepts start.
//
// Ports
//   Clk           system clock, rising edge
//   Reset         synchronous, active-high reset (aborts any collection)
//   start         request a new response (only looked at while idle)
//   arb_q         arbiter flip-flop Q (only looked at in the sample cycle)
//   fire          one-cycle pulse that launches a race
//   chal_idx      index of the bit/challenge being collected
//   busy          high whenever the collector is not idle
//   resp_data     assembled response; bit i is the majority for chal_idx=i
//   resp_valid    response available
//   resp_ready    consumer accepts the response
//   unstable_mask (only with STABILITY_FLAG_EN) bit i set when the votes
//                 for bit i were not unanimous
//
// Build option
//   STABILITY_FLAG_EN  adds the unstable_mask output and its logic.
// ---------------------------------------------------------------------------
module puf_response_collector #(
  parameter  int RESP_BITS     = 32,
  parameter  int VOTES         = 7,
  parameter  int SETTLE_CYCLES = 4,
  localparam int IDX_W         = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 arb_q,
  output logic                 fire,
  output logic [IDX_W-1:0]     chal_idx,
  output logic                 busy,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_valid,
`ifdef STABILITY_FLAG_EN
  output logic [RESP_BITS-1:0] unstable_mask,
`endif
  input  logic                 resp_ready
);

  localparam int CNT_W = $clog2(VOTES + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(RESP_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_VOTE   = CNT_W'(VOTES - 1);
  localparam logic [CNT_W-1:0] ALL_VOTES   = CNT_W'(VOTES);
  localparam logic [CNT_W-1:0] HALF_VOTES  = CNT_W'(VOTES / 2);
  localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_SETTLE,
    S_SAMPLE,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SET_W-1:0] settle_cnt;
  logic [CNT_W-1:0] vote_cnt;
  logic [CNT_W-1:0] ones_cnt;
  logic             maj_bit;

  // The bit is 1 when strictly more than half of the votes were 1.
  // Because VOTES is odd, a tie cannot happen.
  assign maj_bit = (ones_cnt > HALF_VOTES);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: assign state_nxt a default before the case. Then every path
  // assigns it, and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_FIRE;
      S_FIRE:   state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == LAST_SETTLE) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (vote_cnt == LAST_VOTE) ? S_DECIDE : S_FIRE;
      S_DECIDE: state_nxt = (chal_idx == LAST_IDX) ? S_DONE : S_FIRE;
      S_DONE:   if (resp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state. As a result they are all 0 in IDLE,
  // which is also the reset state.
  assign fire       = (state == S_FIRE);
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_DONE);

  // ---------------------------------------------------------------------
  // Counters and response assembly
  // ---------------------------------------------------------------------
  // chal_idx moves only when DECIDE exits, and it returns to 0 when the
  // response is handed off. It therefore stays constant from the first
  // FIRE of a bit through that bit's DECIDE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      settle_cnt <= '0;
      vote_cnt   <= '0;
      ones_cnt   <= '0;
      chal_idx   <= '0;
      resp_data  <= '0;
    end else begin
      unique case (state)
        S_FIRE:   settle_cnt <= '0;
        S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
        S_SAMPLE: begin
          ones_cnt <= ones_cnt + CNT_W'(arb_q);
          vote_cnt <= vote_cnt + 1'b1;
        end
        S_DECIDE: begin
          resp_data[chal_idx] <= maj_bit;
          ones_cnt            <= '0;
          vote_cnt            <= '0;
          if (chal_idx != LAST_IDX) chal_idx <= chal_idx + 1'b1;
        end
        S_DONE:   if (resp_ready) chal_idx <= '0;
        default:  ;
      endcase
    end
  end

`ifdef STABILITY_FLAG_EN
  // A bit is flagged when its votes disagreed, meaning the race is close
  // enough to flip from one evaluation to the next. The mask is cleared when
  // a new collection is accepted. It is then valid alongside resp_valid.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      unstable_mask <= '0;
    end else if (state == S_IDLE && start) begin
      unstable_mask <= '0;
    end else if (state == S_DECIDE) begin
      unstable_mask[chal_idx] <= (ones_cnt != '0) && (ones_cnt != ALL_VOTES);
    end
  end
`endif

endmodule

// File: tb/tb_puf_response_collector.sv
// ---------------------------------------------------------------------------
// Testbench for puf_response_collector (RESP_BITS=4, VOTES=3, SETTLE_CYCLES=2).
// The bench plans a set of votes for each response bit. It drives the vote on
// arb_q only in the cycle where the sample is due, and drives random values
// everywhere else. The expected response is computed by counting the votes.
// Cycle c is the cycle that follows the c-th clock edge after the edge that
// accepts start.
// ---------------------------------------------------------------------------
module tb_puf_response_collector;

  localparam int RB      = 4;
  localparam int NV      = 3;
  localparam int SC      = 2;
  localparam int WIN     = SC + 2;        // cycles per race
  localparam int BIT_LEN = NV * WIN + 1;  // cycles per response bit
  localparam int LAT     = RB * BIT_LEN;  // start edge to resp_valid
  localparam int IW      = 2;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          start;
  logic          arb_q;
  logic          resp_ready;
  logic          fire;
  logic          busy;
  logic          resp_valid;
  logic [IW-1:0] chal_idx;
  logic [RB-1:0] resp_data;
`ifdef STABILITY_FLAG_EN
  logic [RB-1:0] unstable_mask;
`endif

  int total = 0;
  int bad   = 0;

  puf_response_collector #(
    .RESP_BITS     (RB),
    .VOTES         (NV),
    .SETTLE_CYCLES (SC)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .arb_q      (arb_q),
    .fire       (fire),
    .chal_idx   (chal_idx),
    .busy       (busy),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
`ifdef STABILITY_FLAG_EN
    .unstable_mask (unstable_mask),
`endif
    .resp_ready (resp_ready)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: majority and disagreement flag for each bit.
  // votes[b*NV+v] is vote v of bit b.
  function automatic void model(input logic [RB*NV-1:0] votes,
                                output logic [RB-1:0] d, output logic [RB-1:0] m);
    for (int b = 0; b < RB; b++) begin
      int ones = 0;
      for (int v = 0; v < NV; v++) ones += int'(votes[b*NV+v]);
      d[b] = (2 * ones > NV);
      m[b] = (ones != 0) && (ones != NV);
    end
  endfunction

  // Run one collection.
  // abort_at > 0 asserts Reset during that cycle and stops the collection.
  // hold is the number of DONE cycles spent with resp_ready low.
  task automatic collect(input logic [RB*NV-1:0] votes, input int abort_at, input int hold);
    logic [RB-1:0] exp_d;
    logic [RB-1:0] exp_m;
    model(votes, exp_d, exp_m);

    start = 1'b1;
    arb_q = 1'($urandom);
    tick();                       // edge that accepts start
    start = 1'b0;

    for (int c = 1; c <= LAT; c++) begin
      int   b;
      int   w;
      int   v;
      int   ph;
      logic exp_fire;
      b        = (c - 1) / BIT_LEN;
      w        = (c - 1) % BIT_LEN;
      v        = w / WIN;
      ph       = w % WIN;
      exp_fire = (v < NV) && (ph == 0);
      check("fire",       32'(fire),       32'(exp_fire));
      check("chal_idx",   32'(chal_idx),   32'(b));
      check("busy",       32'(busy),       32'd1);
      check("resp_valid", 32'(resp_valid), 32'd0);
      start      = 1'($urandom);            // ignored while busy
      resp_ready = 1'($urandom);            // ignored outside DONE
      arb_q      = (v < NV && ph == WIN - 1) ? votes[b*NV+v] : 1'($urandom);
      if (c == abort_at) Reset = 1'b1;
      tick();
      if (c == abort_at) begin
        check("rst_fire",       32'(fire),       32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_chal_idx",   32'(chal_idx),   32'd0);
        check("rst_resp_data",  32'(resp_data),  32'd0);
`ifdef STABILITY_FLAG_EN
        check("rst_mask",       32'(unstable_mask), 32'd0);
`endif
        Reset      = 1'b0;
        start      = 1'b0;
        resp_ready = 1'b0;
        tick();
        check("rst_idle", 32'(busy), 32'd0);
        return;
      end
    end

    // DONE: with resp_ready low, the response must hold and start is ignored.
    resp_ready = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      check("done_valid", 32'(resp_valid), 32'd1);
      check("done_data",  32'(resp_data),  32'(exp_d));
      check("done_fire",  32'(fire),       32'd0);
      check("done_busy",  32'(busy),       32'd1);
`ifdef STABILITY_FLAG_EN
      check("done_mask",  32'(unstable_mask), 32'(exp_m));
`endif
      if (h < hold) begin
        start = 1'($urandom);
        arb_q = 1'($urandom);
        tick();
      end
    end

    // Handshake, with start high in the same cycle; start must be ignored.
    resp_ready = 1'b1;
    start      = 1'b1;
    tick();
    resp_ready = 1'b0;
    start      = 1'b0;
    check("rel_valid",    32'(resp_valid), 32'd0);
    check("rel_busy",     32'(busy),       32'd0);
    check("rel_chal_idx", 32'(chal_idx),   32'd0);
    check("rel_data",     32'(resp_data),  32'(exp_d));
    tick();
    check("rel_start_ignored", 32'(busy), 32'd0);
    check("rel_no_fire",       32'(fire), 32'd0);
  endtask

  initial begin
    Reset      = 1'b1;
    start      = 1'b0;
    arb_q      = 1'b0;
    resp_ready = 1'b0;
    repeat (3) tick();
    Reset = 1'b0;
    check("reset_fire",       32'(fire),       32'd0);
    check("reset_busy",       32'(busy),       32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_chal_idx",   32'(chal_idx),   32'd0);
    check("reset_resp_data",  32'(resp_data),  32'd0);
`ifdef STABILITY_FLAG_EN
    check("reset_mask",       32'(unstable_mask), 32'd0);
`endif

    // Idle with arb_q toggling: nothing may happen.
    for (int i = 0; i < 20; i++) begin
      arb_q      = ~arb_q;
      resp_ready = 1'($urandom);
      tick();
      check("idle_fire",  32'(fire),       32'd0);
      check("idle_busy",  32'(busy),       32'd0);
      check("idle_valid", 32'(resp_valid), 32'd0);
    end
    resp_ready = 1'b0;

    // All votes 1: response 4'b1111, handed off immediately.
    collect('1, 0, 0);

    // Bit votes (1,0,1) (0,0,1) (1,1,0) (0,0,0): response 4'b0101,
    // unstable 4'b0111. resp_ready is held low for 10 cycles in DONE.
    collect({3'b000, 3'b011, 3'b100, 3'b101}, 0, 10);

    // Reset in cycle 25, then a complete collection.
    collect(12'($urandom), 25, 0);
    collect(12'($urandom), 0, 2);

    // Random votes and random hold times.
    for (int k = 0; k < 6; k++) collect(12'($urandom), 0, int'($urandom_range(5, 0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
